// File: rtl/piece_controller_pkg.sv
// rtl/piece_controller_pkg.sv - shared encodings, state enum, field size and piece ROM
package piece_controller_pkg;

    localparam int FIELD_W     = 20;
    localparam int FIELD_H     = 20;
    localparam int FIELD_CELLS = FIELD_W * FIELD_H;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Bit positions inside the pending-request register
    localparam int PEND_RIGHT = 0;
    localparam int PEND_LEFT  = 1;
    localparam int PEND_ROT   = 2;
    localparam int PEND_DOWN  = 3;

    typedef enum logic [2:0] {
        OP_CHECK = 3'd0,
        OP_ROT   = 3'd1,
        OP_LEFT  = 3'd2,
        OP_RIGHT = 3'd3,
        OP_DOWN  = 3'd4
    } pred_op_t;

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_SPAWN = 3'd1,
        ST_CHECK = 3'd2,
        ST_IDLE  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    // 4x4 masks, row-major, MSB is the top-left cell: I, O, T, S, Z, J, L
    function automatic logic [15:0] piece_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    piece_rom = 16'h0F00;
            3'd1:    piece_rom = 16'h0660;
            3'd2:    piece_rom = 16'h0E40;
            3'd3:    piece_rom = 16'h06C0;
            3'd4:    piece_rom = 16'h0C60;
            3'd5:    piece_rom = 16'h08E0;
            3'd6:    piece_rom = 16'h02E0;
            default: piece_rom = 16'h0F00;
        endcase
    endfunction

endpackage

// File: rtl/piece_controller_gen.sv
// rtl/piece_controller_gen.sv - free-running 8-bit Fibonacci LFSR piece selector
module piece_gen
    import piece_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] idx      // ROM index 0..6
);

    logic [7:0] lfsr;
    logic       feedback;

    // Taps 8,6,5,4 counted from 1
    assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

    // Only seven pieces exist, so the eighth code folds onto the first
    assign idx = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];

endmodule

// File: rtl/piece_controller.sv
// rtl/piece_controller.sv - falling-block game controller driven by external predictors
module piece_controller
    import piece_controller_pkg::*;
#(
    parameter logic [4:0] SPAWN_X = 5'd8,
    parameter int         SCORE_W = 16
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,       // new game from READY/OVER
    input  logic                     btn_rot,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_down,
    input  logic                     tick,        // gravity, same as btn_down
    output logic [0:FIELD_CELLS-1]   field,       // settled cells, y*20+x
    output logic [0:15]              block,       // active 4x4 block
    output logic [4:0]               block_x,
    output logic [4:0]               block_y,
    output logic [2:0]               pred_op,     // operation shown to predictors
    input  logic                     pred_ok,
    input  logic                     pred_touch,
    input  logic                     pred_score,
    input  logic [0:FIELD_CELLS-1]   pred_field,
    input  logic [0:15]              pred_block,
    output logic [SCORE_W-1:0]       score,
    output logic                     game_over,
    output logic                     busy
);

    state_t     state, state_d;
    pred_op_t   op_q, op_d;
    logic [3:0] pend, pend_d, serve, req;
    logic [2:0] piece_idx;
    logic       accept_req;
    logic       clear_game, load_piece, do_rot, do_left, do_right, do_down, do_lock;

    piece_gen u_piece_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (piece_idx)
    );

    assign req        = {btn_down | tick, btn_rot, btn_left, btn_right};
    assign accept_req = (state != ST_READY) && (state != ST_OVER);
    // A fresh pulse re-arms a bit even in the cycle it is being served
    assign pend_d     = (pend & ~serve) | (accept_req ? req : 4'b0000);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_READY;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        op_d       = op_q;
        serve      = 4'b0000;
        pred_op    = OP_CHECK;
        clear_game = 1'b0;
        load_piece = 1'b0;
        do_rot     = 1'b0;
        do_left    = 1'b0;
        do_right   = 1'b0;
        do_down    = 1'b0;
        do_lock    = 1'b0;
        case (state)
            ST_READY, ST_OVER: begin
                if (start) begin
                    clear_game = 1'b1;
                    state_d    = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                load_piece = 1'b1;
                state_d    = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = pred_ok ? ST_IDLE : ST_OVER;
            end
            ST_IDLE: begin
                if (pend[PEND_DOWN]) begin
                    op_d             = OP_DOWN;
                    serve[PEND_DOWN] = 1'b1;
                    state_d          = ST_EVAL;
                end else if (pend[PEND_ROT]) begin
                    op_d            = OP_ROT;
                    serve[PEND_ROT] = 1'b1;
                    state_d         = ST_EVAL;
                end else if (pend[PEND_LEFT]) begin
                    op_d             = OP_LEFT;
                    serve[PEND_LEFT] = 1'b1;
                    state_d          = ST_EVAL;
                end else if (pend[PEND_RIGHT]) begin
                    op_d              = OP_RIGHT;
                    serve[PEND_RIGHT] = 1'b1;
                    state_d           = ST_EVAL;
                end
            end
            ST_EVAL: begin
                pred_op = op_q;
                state_d = ST_IDLE;
                case (op_q)
                    OP_ROT:   do_rot   = pred_ok;
                    OP_LEFT:  do_left  = pred_ok;
                    OP_RIGHT: do_right = pred_ok;
                    OP_DOWN: begin
                        if (pred_touch) begin
                            do_lock = 1'b1;
                            state_d = ST_SPAWN;
                        end else begin
                            do_down = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            field   <= '0;
            block   <= '0;
            block_x <= SPAWN_X;
            block_y <= 5'd0;
            score   <= '0;
            pend    <= 4'b0000;
            op_q    <= OP_CHECK;
        end else begin
            pend <= pend_d;
            op_q <= op_d;
            if (clear_game) begin
                field <= '0;
                score <= '0;
            end
            if (load_piece) begin
                block   <= piece_rom(piece_idx);
                block_x <= SPAWN_X;
                block_y <= 5'd0;
            end
            if (do_rot)   block   <= pred_block;
            if (do_left)  block_x <= block_x - 5'd1;
            if (do_right) block_x <= block_x + 5'd1;
            if (do_down)  block_y <= block_y + 5'd1;
            if (do_lock) begin
                field <= pred_field;
                if (pred_score && (score != '1)) begin
                    score <= score + SCORE_W'(1);
                end
            end
        end
    end

    assign game_over = (state == ST_OVER);
    assign busy      = (state != ST_IDLE) && (state != ST_READY);

endmodule

// File: tb/tb_piece_controller.sv
// tb/tb_piece_controller.sv - directed self-checking bench for piece_controller
module tb_piece_controller;

    logic           clk = 1'b0;
    logic           rst_n, start, btn_rot, btn_left, btn_right, btn_down, tick;
    logic           pred_ok, pred_touch, pred_score;
    logic [0:399]   pred_field;
    logic [0:15]    pred_block;

    logic [0:399]   field, field_s;
    logic [0:15]    block, block_s;
    logic [4:0]     block_x, block_y, block_x_s, block_y_s;
    logic [2:0]     pred_op, pred_op_s;
    logic [15:0]    score;
    logic [1:0]     score_s;
    logic           game_over, busy, game_over_s, busy_s;

    logic [7:0]     m_lfsr;
    logic [15:0]    exp_blk;
    int             n_total = 0;
    int             n_pass  = 0;

    always #5 clk = ~clk;

    piece_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_rot(btn_rot), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .tick(tick), .field(field), .block(block), .block_x(block_x), .block_y(block_y),
        .pred_op(pred_op), .pred_ok(pred_ok), .pred_touch(pred_touch), .pred_score(pred_score),
        .pred_field(pred_field), .pred_block(pred_block), .score(score),
        .game_over(game_over), .busy(busy)
    );

    // Narrow score copy so saturation is reachable in a handful of locks
    piece_controller #(.SPAWN_X(5'd8), .SCORE_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start),
        .btn_rot(btn_rot), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
        .tick(tick), .field(field_s), .block(block_s), .block_x(block_x_s), .block_y(block_y_s),
        .pred_op(pred_op_s), .pred_ok(pred_ok), .pred_touch(pred_touch), .pred_score(pred_score),
        .pred_field(pred_field), .pred_block(pred_block), .score(score_s),
        .game_over(game_over_s), .busy(busy_s)
    );

    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [15:0] exp_rom(input logic [7:0] l);
        case (l[2:0])
            3'd0: exp_rom = 16'h0F00;
            3'd1: exp_rom = 16'h0660;
            3'd2: exp_rom = 16'h0E40;
            3'd3: exp_rom = 16'h06C0;
            3'd4: exp_rom = 16'h0C60;
            3'd5: exp_rom = 16'h08E0;
            3'd6: exp_rom = 16'h02E0;
            default: exp_rom = 16'h0F00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_lock(input logic scr, input logic [399:0] f);
        pred_touch = 1'b1; pred_score = scr; pred_field = f;
        tick = 1'b1; step(1); tick = 1'b0;
        step(3);
        pred_touch = 1'b0; pred_score = 1'b0;
        step(1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; btn_rot = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_down = 1'b0; tick = 1'b0; pred_ok = 1'b0; pred_touch = 1'b0; pred_score = 1'b0;
        pred_field = '0; pred_block = '0;
        step(2);
        check("rst_busy", busy, 0);
        check("rst_over", game_over, 0);
        check("rst_score", score, 0);
        check("rst_field", field, 0);
        check("rst_block", block, 0);
        check("rst_x", block_x, 8);
        check("rst_y", block_y, 0);
        check("rst_op", pred_op, 0);
        rst_n = 1'b1;
        step(2);
        check("ready_hold", busy, 0);

        // start -> SPAWN -> CHECK -> IDLE
        pred_ok = 1'b1; start = 1'b1; step(1); start = 1'b0;
        check("spawn_busy", busy, 1);
        exp_blk = exp_rom(m_lfsr);
        step(1);
        check("check_op", pred_op, 0);
        check("spawn_block", block, exp_blk);
        check("spawn_x", block_x, 8);
        check("spawn_y", block_y, 0);
        step(1);
        check("idle_busy", busy, 0);
        check("idle_score", score, 0);

        // rot + left together: rot served first
        pred_block = 16'hA5C3;
        btn_left = 1'b1; btn_rot = 1'b1; step(1); btn_left = 1'b0; btn_rot = 1'b0;
        check("pend_idle", busy, 0);
        step(1);
        check("eval_rot_op", pred_op, 1);
        check("eval_busy", busy, 1);
        step(1);
        check("rot_block", block, 16'hA5C3);
        check("rot_x", block_x, 8);
        step(1);
        check("eval_left_op", pred_op, 2);
        step(1);
        check("left_x", block_x, 7);
        check("left_idle", busy, 0);

        btn_right = 1'b1; step(1); btn_right = 1'b0;
        step(1);
        check("eval_right_op", pred_op, 3);
        step(1);
        check("right_x", block_x, 8);

        pred_ok = 1'b0; btn_left = 1'b1; step(1); btn_left = 1'b0;
        step(2);
        check("left_reject_x", block_x, 8);
        pred_ok = 1'b1;

        btn_down = 1'b1; step(1); btn_down = 1'b0;
        step(1);
        check("eval_down_op", pred_op, 4);
        step(1);
        check("down_y", block_y, 1);
        check("down_block", block, 16'hA5C3);

        start = 1'b1; step(1); start = 1'b0;
        check("start_ignored_busy", busy, 0);
        check("start_ignored_y", block_y, 1);

        // gravity lock with a cleared line
        pred_touch = 1'b1; pred_score = 1'b1; pred_field = 400'h1;
        tick = 1'b1; step(1); tick = 1'b0;
        step(1);
        check("lock_op", pred_op, 4);
        step(1);
        check("lock_field", field, 400'h1);
        check("lock_score", score, 1);
        check("lock_spawn_busy", busy, 1);
        exp_blk = exp_rom(m_lfsr);
        pred_touch = 1'b0; pred_score = 1'b0;
        step(1);
        check("respawn_block", block, exp_blk);
        check("respawn_x", block_x, 8);
        check("respawn_y", block_y, 0);
        step(1);
        check("respawn_idle", busy, 0);

        // score saturation on the 2-bit copy
        do_lock(1'b1, 400'h3);
        check("score2", score, 2);
        check("sat_score2", score_s, 2);
        do_lock(1'b1, 400'h7);
        check("score3", score, 3);
        check("sat_score3", score_s, 3);
        do_lock(1'b1, 400'hF);
        check("score4", score, 4);
        check("sat_hold", score_s, 3);
        check("field4", field, 400'hF);
        do_lock(1'b0, 400'h1F);
        check("no_line_score", score, 4);
        check("no_line_field", field, 400'h1F);

        // failed spawn -> OVER
        pred_ok = 1'b0; pred_touch = 1'b1; pred_score = 1'b0; pred_field = 400'hF0;
        tick = 1'b1; step(1); tick = 1'b0;
        step(2);
        exp_blk = exp_rom(m_lfsr);
        pred_touch = 1'b0;
        step(2);
        check("over_flag", game_over, 1);
        check("over_busy", busy, 1);
        check("over_field", field, 400'hF0);
        check("over_block", block, exp_blk);
        btn_left = 1'b1; btn_rot = 1'b1; btn_right = 1'b1; btn_down = 1'b1; tick = 1'b1;
        step(1);
        btn_left = 1'b0; btn_rot = 1'b0; btn_right = 1'b0; btn_down = 1'b0; tick = 1'b0;
        step(2);
        check("over_hold", game_over, 1);
        check("over_op", pred_op, 0);
        check("over_x", block_x, 8);
        check("over_y", block_y, 0);
        pred_ok = 1'b1; start = 1'b1; step(1); start = 1'b0;
        check("restart_field", field, 0);
        check("restart_score", score, 0);
        check("restart_sat_score", score_s, 0);
        check("restart_over", game_over, 0);
        exp_blk = exp_rom(m_lfsr);
        step(2);
        check("restart_block", block, exp_blk);
        step(2);
        check("no_stale_busy", busy, 0);
        check("no_stale_op", pred_op, 0);
        check("no_stale_x", block_x, 8);

        // reset in the middle of a lock
        pred_touch = 1'b1; pred_score = 1'b1; pred_field = '1;
        tick = 1'b1; step(1); tick = 1'b0;
        btn_rot = 1'b1; step(1); btn_rot = 1'b0;
        check("midlock_op", pred_op, 4);
        rst_n = 1'b0; step(1);
        check("midrst_field", field, 0);
        check("midrst_score", score, 0);
        check("midrst_busy", busy, 0);
        check("midrst_block", block, 0);
        rst_n = 1'b1; pred_touch = 1'b0; pred_score = 1'b0;
        step(2);
        check("midrst_ready", busy, 0);
        check("midrst_field2", field, 0);
        start = 1'b1; step(1); start = 1'b0;
        exp_blk = exp_rom(m_lfsr);
        step(2);
        check("post_rst_block", block, exp_blk);
        step(2);
        check("pend_cleared_op", pred_op, 0);
        check("pend_cleared_block", block, exp_blk);
        check("pend_cleared_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
